timer_event_logger: RTL and testbench
=====================================

Name: timer_event_logger

Overview:
Avalon-MM slave that sits directly downstream of the interval timer and consumes its `irq` output as a tick.
- Keeps a free-running 32-bit timestamp counter.
- On each rising edge of the tick or of any enabled external event input, captures the timestamp plus a source mask into a FIFO.
- The Nios CPU drains the FIFO over a 16-bit register interface; irq is raised while entries are pending.

Parameters:
DEPTH, 16, FIFO entries; power of 2, range 2..128.
EVT_W, 4, number of external event inputs.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
chipselect  in  1  Avalon slave select.
address  in  3  register word address.
write_n  in  1  active-low write strobe.
read_n  in  1  active-low read strobe; used only for the optional snapshot latch.
writedata  in  16  write data.
readdata  out  16  registered read data.
tick_in  in  1  timer irq, same clock domain.
evt_in  in  EVT_W  asynchronous external events.
irq  out  1  interrupt to CPU.

Behaviour:
- Clock and reset: one clock (`clk`). Reset is synchronous and active-high (`reset`); it is sampled only on the rising clock edge.
- Reset values: readdata=0, irq=0, timestamp=0, FIFO empty, overflow=0, control=0 (all sources disabled).
- Timestamp: increments by 1 every clock; wraps from 0xFFFFFFFF to 0.
- evt_in path:
  - 2-flop synchroniser per bit, then a rising-edge detect.
  - Source-to-capture latency is 3 clocks.
  - Edge-detect history registers update even while the source is disabled, so enabling a source does not create a spurious edge.
- tick_in path: rising-edge detect only; latency is 1 clock.
- Capture:
  - An entry is written when any enabled rising edge occurs.
  - Entry = {mask[EVT_W:0], ts[31:0]}. mask bit EVT_W = tick; bits [EVT_W-1:0] = evt_in.
  - Coincident edges in the same cycle produce one entry with several mask bits set.
  - The timestamp stored is the counter value in the capture cycle.
- FIFO full:
  - A capture is dropped and overflow is set (sticky).
  - If a pop occurs in the same cycle, the capture is accepted and overflow is not set.
- Register map (word addresses):
  - 0 STATUS, read: [0] nonempty, [1] full, [2] overflow, [15:8] count. Write of any value clears overflow; if a drop occurs in the same cycle, the set wins.
  - 1 CONTROL, read/write: [EVT_W-1:0] evt enable, [8] tick enable, [9] irq enable, [10] flush. Flush self-clears and reads 0.
  - 2 HEAD_TS_L, read-only: head timestamp[15:0].
  - 3 HEAD_TS_H, read-only: head timestamp[31:16].
  - 4 HEAD_SRC, read-only: head mask, zero-extended.
  - 5 POP, write-only: a write of any value pops the head. A pop on an empty FIFO is ignored.
  - 6, 7: see Optional Feature.
  - Unmapped reads return 0.
- Reads:
  - readdata is registered; it reflects address/state from the previous cycle (1-clock latency). It updates every cycle regardless of chipselect.
  - Head registers read 0 when the FIFO is empty.
- Flush:
  - Empties the FIFO in the cycle after the write.
  - Captures in the flush cycle are dropped without setting overflow.
  - Overflow is not cleared by flush.
- irq: registered; irq = nonempty && irq_en, one clock after the state change.
- Reset mid-operation: all state returns to reset values on the next edge; pending entries are lost.

Optional Feature:
Macro TIMER_EVENT_LOGGER_SNAPSHOT_EN.
- Defined:
  - A read of address 6 (chipselect && !read_n) returns live timestamp[15:0].
  - The same read latches timestamp[31:16] into a shadow register.
  - Address 7 returns the shadow, so the 32-bit live time is coherent.
  - Shadow reset value is 0.
- Undefined: addresses 6 and 7 read 0, no shadow register exists, and read_n is unused.

Decomposition:
- Package timer_event_logger_pkg:
  - Register address constants.
  - STATUS/CONTROL bit-position constants.
  - TS_W=32.
  - Entry struct typedef (mask, ts).
- One sub-module, tel_sync_fifo:
  - Single-clock FIFO, parameterised width/depth.
  - Ports: push, pop, flush, full, empty, count, head data.
  - Show-ahead head output.
  - Simultaneous push+pop when full is legal.

Test Plan:
- Reset, then set CONTROL=0x0100 (tick only) and pulse tick_in at ts=100 → one entry; HEAD_TS_L=100 (tick edge at timestamp 100), HEAD_SRC=0x10, STATUS=0x0101.
- Enable evt[0] and evt[2]; raise both in one cycle → single entry, HEAD_SRC=0x05; stored ts = edge cycle ts+2 (edge detect fires 2 clocks after the input rises, 3 clocks to the FIFO write).
- With 16 captures and no pops, a 17th edge → STATUS=0x1007 (count 16, full, overflow); a STATUS write clears it to 0x1003.
- When full, an edge coinciding with a POP write → count stays 16, overflow stays 0, and the new entry appears last.
- Set irq_en with 1 entry → irq=1 one clock later; POP → irq=0 one clock after the FIFO empties; head reads return 0.
- With TIMER_EVENT_LOGGER_SNAPSHOT_EN and ts=0x0001FFFF at the read of address 6 → returns 0xFFFF; a later read of address 7 returns 0x0001 despite the counter rollover to 0x00020000.

Source files
------------

// File: rtl/timer_event_logger_pkg.sv
// Shared constants for timer_event_logger: register map, bit positions and
// the layout of one captured FIFO entry.
package timer_event_logger_pkg;

  localparam int TS_W   = 32;
  // Stored source mask: the tick bit plus up to 8 external event bits.
  localparam int MASK_W = 9;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_HEAD_TL = 3'd2;
  localparam logic [2:0] ADDR_HEAD_TH = 3'd3;
  localparam logic [2:0] ADDR_HEAD_SRC = 3'd4;
  localparam logic [2:0] ADDR_POP     = 3'd5;
  localparam logic [2:0] ADDR_SNAP_L  = 3'd6;
  localparam logic [2:0] ADDR_SNAP_H  = 3'd7;

  localparam int ST_NONEMPTY  = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_COUNT_LSB = 8;

  localparam int CTL_TICK_EN = 8;
  localparam int CTL_IRQ_EN  = 9;
  localparam int CTL_FLUSH   = 10;

  typedef struct packed {
    logic [MASK_W-1:0] mask;
    logic [TS_W-1:0]   ts;
  } entry_t;

endpackage

// File: rtl/tel_sync_fifo.sv
// Single-clock show-ahead FIFO. The head word is always visible on head_o;
// push and pop may happen together even when full. Flush has priority.
module tel_sync_fifo #(
  parameter int WIDTH = 41,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [WIDTH-1:0]           head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == FULL_CNT);
  assign count_o   = count_q;
  assign head_o    = mem_q[rd_ptr_q];
  assign do_pop_s  = pop_i & ~empty_o & ~flush_i;
  assign do_push_s = push_i & ~flush_i & (~full_o | do_pop_s);

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_s) wr_ptr_d = wr_ptr_q + AW'(1);
      else           wr_ptr_d = wr_ptr_q;
      if (do_pop_s)  rd_ptr_d = rd_ptr_q + AW'(1);
      else           rd_ptr_d = rd_ptr_q;
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/timer_event_logger.sv
// timer_event_logger: timestamps rising edges of the timer tick and of
// external events into a FIFO that the CPU drains over a 16-bit register port.
// Optional live-timestamp snapshot registers: TIMER_EVENT_LOGGER_SNAPSHOT_EN.
module timer_event_logger
  import timer_event_logger_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int EVT_W = 4   // at most MASK_W-1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chipselect,
  input  logic [2:0]       address,
  input  logic             write_n,
  input  logic             read_n,
  input  logic [15:0]      writedata,
  output logic [15:0]      readdata,
  input  logic             tick_in,
  input  logic [EVT_W-1:0] evt_in,
  output logic             irq
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [TS_W-1:0]  ts_q, ts_d;
  logic             tick_prev_q, tick_prev_d;
  logic [EVT_W-1:0] evt_s1_q, evt_s1_d, evt_s2_q, evt_s2_d, evt_prev_q, evt_prev_d;
  logic [EVT_W-1:0] evt_en_q, evt_en_d;
  logic             tick_en_q, tick_en_d, irq_en_q, irq_en_d;
  logic             flush_q, flush_d, ovf_q, ovf_d, irq_q, irq_d;
  logic [15:0]      readdata_q, readdata_d;

  logic             wr_s, pop_req_s, pop_ok_s, capture_s, push_s, drop_s;
  logic [EVT_W:0]   edges_s;
  logic             full_s, empty_s;
  logic [CNT_W-1:0] count_s;
  entry_t           cap_s, head_s;
  logic             unused_s;

  assign wr_s      = chipselect & ~write_n;
  assign pop_req_s = wr_s & (address == ADDR_POP);
  assign pop_ok_s  = pop_req_s & ~empty_s;
  // Tick is edge-detected straight off the input; events use the synchronised copy.
  assign edges_s   = {tick_in & ~tick_prev_q & tick_en_q, evt_s2_q & ~evt_prev_q & evt_en_q};
  assign capture_s = |edges_s;
  // Captures in a flush cycle are discarded silently.
  assign push_s    = capture_s & ~flush_q;
  assign drop_s    = push_s & full_s & ~pop_ok_s;
  assign cap_s     = {MASK_W'(edges_s), ts_q};
  assign readdata  = readdata_q;
  assign irq       = irq_q;
  assign unused_s  = ^{read_n, writedata};

  tel_sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_s),
    .pop_i   (pop_req_s),
    .flush_i (flush_q),
    .din_i   (cap_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (count_s),
    .head_o  (head_s)
  );

`ifdef TIMER_EVENT_LOGGER_SNAPSHOT_EN
  logic [15:0] shadow_q, shadow_d;

  // Latch the upper timestamp half whenever the low half is read.
  always_comb begin
    if (chipselect && !read_n && (address == ADDR_SNAP_L)) shadow_d = ts_q[31:16];
    else                                                   shadow_d = shadow_q;
  end

  // Shadow register for coherent 32-bit time reads.
  always_ff @(posedge clk) begin
    if (reset) shadow_q <= 16'h0000;
    else       shadow_q <= shadow_d;
  end
`endif

  // Timestamp, edge history, control and overflow next-state.
  always_comb begin
    ts_d        = ts_q + 32'd1;
    tick_prev_d = tick_in;
    evt_s1_d    = evt_in;
    evt_s2_d    = evt_s1_q;
    evt_prev_d  = evt_s2_q;
    evt_en_d    = evt_en_q;
    tick_en_d   = tick_en_q;
    irq_en_d    = irq_en_q;
    flush_d     = 1'b0;
    ovf_d       = ovf_q;
    if (wr_s && (address == ADDR_CONTROL)) begin
      evt_en_d  = writedata[EVT_W-1:0];
      tick_en_d = writedata[CTL_TICK_EN];
      irq_en_d  = writedata[CTL_IRQ_EN];
      flush_d   = writedata[CTL_FLUSH];
    end else begin
      flush_d   = 1'b0;
    end
    // A drop in the same cycle as a clear leaves overflow set.
    if (drop_s)                                  ovf_d = 1'b1;
    else if (wr_s && (address == ADDR_STATUS))   ovf_d = 1'b0;
    else                                         ovf_d = ovf_q;
    irq_d = irq_en_q & ~empty_s;
  end

  // Read mux; sampled every cycle so readdata trails address by one clock.
  always_comb begin
    readdata_d = 16'h0000;
    case (address)
      ADDR_STATUS: begin
        readdata_d[ST_NONEMPTY]            = ~empty_s;
        readdata_d[ST_FULL]                = full_s;
        readdata_d[ST_OVF]                 = ovf_q;
        readdata_d[ST_COUNT_LSB +: 8]      = 8'(count_s);
      end
      ADDR_CONTROL: begin
        readdata_d[EVT_W-1:0]   = evt_en_q;
        readdata_d[CTL_TICK_EN] = tick_en_q;
        readdata_d[CTL_IRQ_EN]  = irq_en_q;
      end
      ADDR_HEAD_TL:  readdata_d = empty_s ? 16'h0000 : head_s.ts[15:0];
      ADDR_HEAD_TH:  readdata_d = empty_s ? 16'h0000 : head_s.ts[31:16];
      ADDR_HEAD_SRC: readdata_d = empty_s ? 16'h0000 : 16'(head_s.mask);
`ifdef TIMER_EVENT_LOGGER_SNAPSHOT_EN
      ADDR_SNAP_L:   readdata_d = ts_q[15:0];
      ADDR_SNAP_H:   readdata_d = shadow_q;
`else
      ADDR_SNAP_L:   readdata_d = 16'h0000;
      ADDR_SNAP_H:   readdata_d = 16'h0000;
`endif
      default:       readdata_d = 16'h0000;
    endcase
  end

  // All top-level state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q        <= '0;
      tick_prev_q <= 1'b0;
      evt_s1_q    <= '0;
      evt_s2_q    <= '0;
      evt_prev_q  <= '0;
      evt_en_q    <= '0;
      tick_en_q   <= 1'b0;
      irq_en_q    <= 1'b0;
      flush_q     <= 1'b0;
      ovf_q       <= 1'b0;
      irq_q       <= 1'b0;
      readdata_q  <= 16'h0000;
    end else begin
      ts_q        <= ts_d;
      tick_prev_q <= tick_prev_d;
      evt_s1_q    <= evt_s1_d;
      evt_s2_q    <= evt_s2_d;
      evt_prev_q  <= evt_prev_d;
      evt_en_q    <= evt_en_d;
      tick_en_q   <= tick_en_d;
      irq_en_q    <= irq_en_d;
      flush_q     <= flush_d;
      ovf_q       <= ovf_d;
      irq_q       <= irq_d;
      readdata_q  <= readdata_d;
    end
  end

endmodule

// File: tb/tb_timer_event_logger.sv
// Self-checking bench for timer_event_logger: directed scenarios plus a
// randomized run, all compared against a queue-based reference model.
module tb_timer_event_logger;

  localparam int DEPTH = 16;
  localparam int EVT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             chipselect;
  logic [2:0]       address;
  logic             write_n;
  logic             read_n;
  logic [15:0]      writedata;
  logic [15:0]      readdata;
  logic             tick_in;
  logic [EVT_W-1:0] evt_in;
  logic             irq;

  int checks = 0;
  int failures = 0;

  timer_event_logger #(.DEPTH(DEPTH), .EVT_W(EVT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .chipselect (chipselect),
    .address    (address),
    .write_n    (write_n),
    .read_n     (read_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .tick_in    (tick_in),
    .evt_in     (evt_in),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Reference model state.
  typedef struct {
    logic [EVT_W:0] mask;
    logic [31:0]    ts;
  } ent_t;

  ent_t             m_q[$];
  logic [31:0]      tb_ts;
  logic             m_ovf, m_tick_en, m_irq_en, m_flush_now;
  logic [EVT_W-1:0] m_evt_en;
  logic [15:0]      m_shadow;
  logic             h_tick1;
  logic [EVT_W-1:0] h_evt1, h_evt2, h_evt3;
  logic [15:0]      m_rd_exp;
  logic             m_irq_exp;

  function automatic logic [15:0] model_rd(input logic [2:0] a);
    logic [15:0] r;
    r = 16'h0000;
    case (a)
      3'd0: begin
        r[15:8] = 8'(m_q.size());
        r[2] = m_ovf;
        r[1] = (m_q.size() == DEPTH);
        r[0] = (m_q.size() != 0);
      end
      3'd1: begin
        r[EVT_W-1:0] = m_evt_en;
        r[8] = m_tick_en;
        r[9] = m_irq_en;
      end
      3'd2: if (m_q.size() != 0) r = m_q[0].ts[15:0];
      3'd3: if (m_q.size() != 0) r = m_q[0].ts[31:16];
      3'd4: if (m_q.size() != 0) r = 16'(m_q[0].mask);
`ifdef TIMER_EVENT_LOGGER_SNAPSHOT_EN
      3'd6: r = tb_ts[15:0];
      3'd7: r = m_shadow;
`endif
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

  // Advance one clock: apply the model rules for this cycle, then clock the DUT.
  task automatic step();
    logic [EVT_W:0] edges;
    logic wr, pop_ok, accept, drop;
    logic [31:0] next_ts;
    ent_t e;
    if (reset) begin
      m_rd_exp = 16'h0000; m_irq_exp = 1'b0;
      m_q.delete(); m_ovf = 1'b0; m_evt_en = '0; m_tick_en = 1'b0; m_irq_en = 1'b0;
      m_flush_now = 1'b0; m_shadow = 16'h0000;
      h_tick1 = 1'b0; h_evt1 = '0; h_evt2 = '0; h_evt3 = '0;
      next_ts = 32'd0;
    end else begin
      m_rd_exp  = model_rd(address);
      m_irq_exp = m_irq_en && (m_q.size() != 0);
      edges[EVT_W] = tick_in && !h_tick1 && m_tick_en;
      for (int b = 0; b < EVT_W; b++) edges[b] = h_evt2[b] && !h_evt3[b] && m_evt_en[b];
      wr     = chipselect && !write_n;
      pop_ok = wr && (address == 3'd5) && (m_q.size() != 0);
      drop   = 1'b0;
      if (m_flush_now) begin
        m_q.delete();
      end else begin
        accept = (edges != '0) && ((m_q.size() < DEPTH) || pop_ok);
        drop   = (edges != '0) && !accept;
        if (pop_ok) void'(m_q.pop_front());
        if (accept) begin
          e.mask = edges; e.ts = tb_ts;
          m_q.push_back(e);
        end
      end
      if (drop) m_ovf = 1'b1;
      else if (wr && (address == 3'd0)) m_ovf = 1'b0;
      m_flush_now = wr && (address == 3'd1) && writedata[10];
      if (wr && (address == 3'd1)) begin
        m_evt_en = writedata[EVT_W-1:0]; m_tick_en = writedata[8]; m_irq_en = writedata[9];
      end
      if (chipselect && !read_n && (address == 3'd6)) m_shadow = tb_ts[31:16];
      h_evt3 = h_evt2; h_evt2 = h_evt1; h_evt1 = evt_in; h_tick1 = tick_in;
      next_ts = tb_ts + 32'd1;
    end
    @(posedge clk);
    #1;
    tb_ts = next_ts;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    step();
    chipselect = 1'b0; write_n = 1'b1; writedata = 16'h0000;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    chipselect = 1'b1; read_n = 1'b0; address = a;
    step();
    chipselect = 1'b0; read_n = 1'b1;
    d = readdata;
  endtask

  task automatic pulse_tick(input int n);
    for (int i = 0; i < n; i++) begin
      tick_in = 1'b1; step();
      tick_in = 1'b0; step();
    end
  endtask

  task automatic test_reset();
    logic [15:0] d;
    reset = 1'b1; step(); step(); reset = 1'b0;
    checks++; if (readdata !== 16'h0000) begin failures++; $display("FAIL reset_readdata got=%h exp=0000", readdata); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    bus_read(3'd0, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL reset_status got=%h exp=0000", d); end
  endtask

  task automatic test_tick();
    logic [15:0] d;
    bus_write(3'd1, 16'h0100);
    for (int i = 0; i < 200 && tb_ts < 32'd100; i++) step();
    checks++; if (tb_ts !== 32'd100) begin failures++; $display("FAIL tick_align got=%0d exp=100", tb_ts); end
    tick_in = 1'b1; step(); tick_in = 1'b0;
    bus_read(3'd2, d);
    checks++; if (d !== 16'd100 || d !== m_rd_exp) begin failures++; $display("FAIL tick_head_ts got=%h exp=%h", d, 16'd100); end
    bus_read(3'd4, d);
    checks++; if (d !== 16'h0010) begin failures++; $display("FAIL tick_head_src got=%h exp=0010", d); end
    bus_read(3'd0, d);
    checks++; if (d !== 16'h0101) begin failures++; $display("FAIL tick_status got=%h exp=0101", d); end
  endtask

  task automatic test_evt();
    logic [15:0] d;
    logic [31:0] t;
    bus_write(3'd5, 16'h0000);
    bus_write(3'd1, 16'h0005);
    step(); step(); step();
    t = tb_ts;
    evt_in = 4'b0101;
    for (int i = 0; i < 5; i++) step();
    bus_read(3'd4, d);
    checks++; if (d !== 16'h0005) begin failures++; $display("FAIL evt_head_src got=%h exp=0005", d); end
    bus_read(3'd2, d);
    checks++; if (d !== 16'(t + 32'd2)) begin failures++; $display("FAIL evt_head_ts got=%h exp=%h", d, 16'(t + 32'd2)); end
    bus_read(3'd0, d);
    checks++; if (d !== 16'h0101) begin failures++; $display("FAIL evt_single_entry got=%h exp=0101", d); end
    evt_in = '0;
  endtask

  task automatic test_overflow();
    logic [15:0] d;
    bus_write(3'd5, 16'h0000);
    bus_write(3'd1, 16'h0100);
    pulse_tick(17);
    bus_read(3'd0, d);
    checks++; if (d !== 16'h1007) begin failures++; $display("FAIL ovf_status got=%h exp=1007", d); end
    bus_write(3'd0, 16'h0000);
    bus_read(3'd0, d);
    checks++; if (d !== 16'h1003) begin failures++; $display("FAIL ovf_clear got=%h exp=1003", d); end
  endtask

  task automatic test_full_pop();
    logic [15:0] d;
    logic [31:0] t;
    t = tb_ts;
    tick_in = 1'b1;
    bus_write(3'd5, 16'h0000);
    tick_in = 1'b0;
    bus_read(3'd0, d);
    checks++; if (d !== 16'h1003) begin failures++; $display("FAIL fullpop_status got=%h exp=1003", d); end
    for (int i = 0; i < DEPTH; i++) begin
      bus_read(3'd2, d);
      checks++; if (d !== m_rd_exp) begin failures++; $display("FAIL drain_ts_l[%0d] got=%h exp=%h", i, d, m_rd_exp); end
      if (i == DEPTH - 1) begin
        checks++; if (d !== t[15:0]) begin failures++; $display("FAIL fullpop_last got=%h exp=%h", d, t[15:0]); end
      end
      bus_read(3'd4, d);
      checks++; if (d !== 16'h0010) begin failures++; $display("FAIL drain_src[%0d] got=%h exp=0010", i, d); end
      bus_write(3'd5, 16'h0000);
    end
  endtask

  task automatic test_irq();
    logic [15:0] d;
    bus_write(3'd1, 16'h0300);
    tick_in = 1'b1; step(); tick_in = 1'b0;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_early got=%b exp=0", irq); end
    step();
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_set got=%b exp=1", irq); end
    bus_write(3'd5, 16'h0000);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_hold got=%b exp=1", irq); end
    step();
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b exp=0", irq); end
    bus_read(3'd2, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL empty_head_ts got=%h exp=0000", d); end
    bus_read(3'd4, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL empty_head_src got=%h exp=0000", d); end
  endtask

  task automatic test_flush();
    logic [15:0] d;
    bus_write(3'd1, 16'h0100);
    pulse_tick(17);
    bus_write(3'd1, 16'h0500);
    tick_in = 1'b1; step(); tick_in = 1'b0;
    bus_read(3'd0, d);
    checks++; if (d !== 16'h0004) begin failures++; $display("FAIL flush_status got=%h exp=0004", d); end
    bus_read(3'd1, d);
    checks++; if (d !== 16'h0100) begin failures++; $display("FAIL flush_selfclear got=%h exp=0100", d); end
  endtask

  task automatic test_snapshot();
    logic [15:0] d;
    logic [31:0] t;
    t = tb_ts;
    bus_read(3'd6, d);
`ifdef TIMER_EVENT_LOGGER_SNAPSHOT_EN
    checks++; if (d !== t[15:0]) begin failures++; $display("FAIL snap_low got=%h exp=%h", d, t[15:0]); end
    step(); step();
    bus_read(3'd7, d);
    checks++; if (d !== t[31:16]) begin failures++; $display("FAIL snap_high got=%h exp=%h", d, t[31:16]); end
`else
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL snap6_zero got=%h exp=0000 ts=%h", d, t); end
    bus_read(3'd7, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL snap7_zero got=%h exp=0000", d); end
`endif
  endtask

  task automatic test_random();
    int r;
    logic [15:0] ctl;
    bus_write(3'd0, 16'h0000);
    ctl = 16'h0100 | 16'($urandom_range(0, 15)) | (16'($urandom_range(0, 1)) << 9);
    bus_write(3'd1, ctl);
    for (int i = 0; i < 400; i++) begin
      tick_in    = 1'($urandom_range(0, 1));
      evt_in     = 4'($urandom);
      chipselect = 1'($urandom_range(0, 1));
      read_n     = 1'($urandom_range(0, 1));
      write_n    = 1'b1;
      address    = 3'($urandom);
      writedata  = 16'($urandom);
      r = $urandom_range(0, 99);
      if (r < 35)      begin chipselect = 1'b1; write_n = 1'b0; address = 3'd5; end
      else if (r < 38) begin chipselect = 1'b1; write_n = 1'b0; address = 3'd0; end
      else if (r < 39) begin chipselect = 1'b1; write_n = 1'b0; address = 3'd1; writedata[8] = 1'b1; end
      step();
      checks++; if (readdata !== m_rd_exp) begin failures++; $display("FAIL rand_readdata cyc=%0d got=%h exp=%h", i, readdata, m_rd_exp); end
      checks++; if (irq !== m_irq_exp) begin failures++; $display("FAIL rand_irq cyc=%0d got=%b exp=%b", i, irq, m_irq_exp); end
    end
    chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1; tick_in = 1'b0; evt_in = '0; writedata = 16'h0000;
    step();
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    bus_write(3'd1, 16'h0300);
    pulse_tick(3);
    reset = 1'b1; step(); reset = 1'b0;
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL midreset_irq got=%b exp=0", irq); end
    bus_read(3'd0, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL midreset_status got=%h exp=0000", d); end
    bus_read(3'd1, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL midreset_control got=%h exp=0000", d); end
  endtask

  initial begin
    reset = 1'b1; chipselect = 1'b0; address = 3'd0; write_n = 1'b1; read_n = 1'b1;
    writedata = 16'h0000; tick_in = 1'b0; evt_in = '0; tb_ts = 32'd0;
    test_reset();
    test_tick();
    test_evt();
    test_overflow();
    test_full_pop();
    test_irq();
    test_flush();
    test_snapshot();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
